// File: rtl/booth_mul_sched_pkg.sv
// Shared types for the two-requester Booth multiplier scheduler.
// Declarations only: no timing and no flow control of its own.
package booth_sched_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic req_id_t;

    // {Q[0],E} pair values that modify the partial product
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mul_sched_if.sv
// Requester and result handshake bundle for booth_mul_sched.
// Master drives requests and consumes results; slave is the multiplier.
interface booth_mul_sched_if #(
    parameter int WIDTH = booth_sched_pkg::WIDTH_DEF
);
    import booth_sched_pkg::*;

    logic               req0_valid;
    logic [WIDTH-1:0]   req0_x;
    logic [WIDTH-1:0]   req0_y;
    logic               req0_ready;

    logic               req1_valid;
    logic [WIDTH-1:0]   req1_x;
    logic [WIDTH-1:0]   req1_y;
    logic               req1_ready;

    logic               res_valid;
    logic [2*WIDTH-1:0] res_z;
    req_id_t            res_id;
    logic               res_ready;

    modport master (
        output req0_valid, req0_x, req0_y,
        input  req0_ready,
        output req1_valid, req1_x, req1_y,
        input  req1_ready,
        input  res_valid, res_z, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_x, req0_y,
        output req0_ready,
        input  req1_valid, req1_x, req1_y,
        output req1_ready,
        output res_valid, res_z, res_id,
        input  res_ready
    );

endinterface

// File: rtl/booth_mul_sched_step_engine.sv
// Radix-2 Booth datapath: A/Q/E/M registers plus step counter, one step per i_step.
// o_prod_next is the product as it will stand after the current step; no backpressure.
module booth_step_engine #(
    parameter int WIDTH = booth_sched_pkg::WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]   i_y,
    output logic               o_last_step,
    output logic [2*WIDTH-1:0] o_prod_next
);
    import booth_sched_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // A carries one guard bit so that A - M cannot overflow for M = -2^(WIDTH-1)
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_e;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_a_sum;

    assign w_m_ext = {r_m[WIDTH-1], r_m};

    always_comb begin
        w_a_sum = r_a;
        case ({r_q[0], r_e})
            BOOTH_SUB: w_a_sum = r_a - w_m_ext;
            BOOTH_ADD: w_a_sum = r_a + w_m_ext;
            default:   w_a_sum = r_a;
        endcase
    end

    // Low 2*WIDTH bits of the shifted {A,Q}: the guard bit is dropped by the shift
    assign o_prod_next = {w_a_sum, r_q[WIDTH-1:1]};
    assign o_last_step = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_e   <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= '0;
            r_q   <= i_x;
            r_m   <= i_y;
            r_e   <= 1'b0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_a   <= {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
            r_q   <= {w_a_sum[0], r_q[WIDTH-1:1]};
            r_e   <= r_q[0];
            r_cnt <= o_last_step ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin shares one iterative Booth multiplier between two requesters.
// Latency WIDTH+1 cycles from accept; result held until res_ready, no new accept meanwhile.
module booth_mul_sched #(
    parameter int WIDTH = booth_sched_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    booth_mul_sched_if.slave bus,
    output logic             busy
);
    import booth_sched_pkg::*;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]         r_state;
    req_id_t            r_last;
    req_id_t            r_id;
    req_id_t            r_res_id;
    logic               r_res_vld;
    logic [2*WIDTH-1:0] r_res_z;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_hs;
    req_id_t            w_sel;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic               w_last_step;
    logic [2*WIDTH-1:0] w_prod_next;

    // On a tie the requester that did not win last time gets the engine
    assign w_idle = (r_state == S_IDLE) && !rst;
    assign w_gnt0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last);
    assign w_hs   = w_gnt0 || w_gnt1;
    assign w_sel  = w_gnt1;
    assign w_x    = w_gnt1 ? bus.req1_x : bus.req0_x;
    assign w_y    = w_gnt1 ? bus.req1_y : bus.req0_y;

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.res_valid  = r_res_vld;
    assign bus.res_z      = r_res_z;
    assign bus.res_id     = r_res_id;
    assign busy           = (r_state != S_IDLE);

    booth_step_engine #(
        .WIDTH(WIDTH)
    ) u_engine (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_hs),
        .i_step      (r_state == S_RUN),
        .i_x         (w_x),
        .i_y         (w_y),
        .o_last_step (w_last_step),
        .o_prod_next (w_prod_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_res_id  <= 1'b0;
            r_res_vld <= 1'b0;
            r_res_z   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_state <= S_RUN;
                        r_id    <= w_sel;
                        r_last  <= w_sel;
                    end
                end
                S_RUN: begin
                    // Capture the product produced by the final step directly
                    if (w_last_step) begin
                        r_state   <= S_DONE;
                        r_res_vld <= 1'b1;
                        r_res_z   <= w_prod_next;
                        r_res_id  <= r_id;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state   <= S_IDLE;
                        r_res_vld <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Shares one iterative radix-2 Booth multiply engine between two requesters. Each requester presents a signed operand pair with a valid/ready handshake. A round-robin arbiter grants the engine, one Booth add/sub-and-shift step executes per clock, and the product is returned on a single result port tagged with the requester id. The block sits between the input-decode logic and the output pins, replacing the purely combinational multiplier where area matters more than latency.

## Interface
- `WIDTH`, default 4: operand width in bits, two's complement signed; product is 2*WIDTH bits.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 presents an operand pair.
- `req0_x` input WIDTH: requester 0 multiplier X, signed.
- `req0_y` input WIDTH: requester 0 multiplicand Y, signed.
- `req0_ready` output 1: requester 0 pair accepted this cycle when high together with `req0_valid`.
- `req1_valid`, `req1_x`, `req1_y`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid` output 1: `res_z` and `res_id` are valid.
- `res_z` output 2*WIDTH: signed product X*Y.
- `res_id` output 1: requester that owns `res_z`.
- `res_ready` input 1: consumer accepts the result.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - Arbiter picks one requester with valid high; its ready is driven high combinationally that cycle; the other ready stays low.
  - On handshake: load A=0, Q=X, E=0, M=Y, step counter=0, latch id, go to RUN.
- **Arbitration:** round-robin on a `last` pointer.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to `last` wins.
  - `last` updates on every accepted request. Reset value of `last` is 1, so requester 0 wins the first tie.
- **RUN**, one step per cycle:
  - Pair {Q[0],E}=10: A = A − M.
  - Pair 01: A = A + M.
  - Pair 00 or 11: A unchanged.
  - Then arithmetic shift right of {A,Q,E} by 1. A's MSB is replicated.
  - A is computed at WIDTH+1 bits internally so −M does not overflow when M = −2^(WIDTH−1).
  - After step WIDTH−1 (counter wraps), go to DONE.
- **DONE**
  - `res_valid`=1, `res_z`={A[WIDTH−1:0],Q}, `res_id`=latched id.
  - Outputs are held stable until `res_ready`=1. Then return to IDLE.
  - No request is accepted in RUN or DONE; both readys are low.
- **Reset** (any state, including mid-RUN): state=IDLE, `last`=1, A/Q/E/M/counter/id=0, `res_valid`=0, `res_z`=0, `res_id`=0, both readys=0 in the reset cycle, `busy`=0. The in-flight operation is discarded and no result is produced.
- Requester inputs are sampled only at handshake. Later changes to X/Y do not affect the running operation.

## Timing
- Handshake at edge t. RUN occupies edges t+1 … t+WIDTH. `res_valid` is high from cycle t+WIDTH+1.
- Latency is WIDTH+1 cycles, independent of operand values.
- Result consumed at edge u (`res_valid`&`res_ready`). IDLE in cycle u+1, so a new handshake is possible at edge u+1.
- Peak throughput is one product per WIDTH+2 cycles.
- `res_ready` high on DONE entry: the result is still presented for one cycle. There is no zero-cycle bypass.
- All outputs are registered except `req*_ready`, which is a function of state, `last`, and the valids.

## Structure
- Package `booth_sched_pkg` holds:
  - state enum {IDLE, RUN, DONE};
  - `WIDTH` default constant;
  - requester-id type (1 bit);
  - Booth pair encodings (ADD=01, SUB=10).
- Sub-module `booth_step_engine` holds the A/Q/E/M registers and counter, with load, step, and last-step outputs.
- The top holds the arbiter, FSM, and result/id registers.

## Test plan
- **Basic product:** reset, then req0 X=3,Y=5 with res_ready=1 → res_valid at t+5, res_z=0x0F, res_id=0, busy high for cycles t+1…t+5.
- **Signed corners:**
  - X=−8,Y=−8 → res_z=0x40.
  - X=−8,Y=7 → res_z=0xC8.
  - X=7,Y=−1 → res_z=0xF9.
  - X=0,Y=−3 → res_z=0x00.
  - Exhaustive sweep of all 256 pairs matches the signed reference product.
- **Tie arbitration:** req0 and req1 both held valid continuously → grants alternate 0,1,0,1, with res_id matching. The first grant after reset goes to 0.
- **Backpressure:** res_ready=0 for 10 cycles after DONE → res_z and res_id stable, both readys low. Raising res_ready → IDLE next cycle, and the pending requester is accepted the cycle after.
- **Reset mid-run:** assert rst at the third RUN cycle → next cycle res_valid=0, busy=0, res_z=0. A new request after reset completes correctly with full latency.
- **Operand change after accept:** change req0_x/req0_y during RUN → result reflects the values captured at handshake.
